serial_borrow_subtractor: RTL and testbench
===========================================

// Module: serial_borrow_subtractor
// PURPOSE
//   Bit-serial N-bit subtractor: diff = a - b - bin, computed LSB-first through one
//   full-subtractor cell over N clock cycles, with the borrow held in a flop between bits.
//   Counterpart to the ripple-carry adders: it covers the subtract path where area matters
//   more than latency. Sits behind a start/busy/done handshake in datapath sequencers.
// PARAMETERS
//   N        8    operand width in bits (N >= 1)
// PORTS
//   clk      input   1    single clock; all state updates on rising edge
//   rst      input   1    synchronous, active-high reset
//   start    input   1    request; operands sampled when accepted
//   a        input   N    minuend
//   b        input   N    subtrahend
//   bin      input   1    borrow-in (subtracted in at bit 0)
//   busy     output  1    high while bits are being processed
//   done     output  1    single-cycle pulse; diff/bout valid from this cycle on
//   diff     output  N    result a - b - bin, modulo 2^N
//   bout     output  1    borrow-out; 1 iff a < b + bin (unsigned)
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is synchronous and active-high.
//   - Reset: state=IDLE; busy=0; done=0; diff=0; bout=0; bit counter=0; shift regs=0.
//     Reset taking effect mid-operation aborts that operation; no done pulse for it.
//   - FSM states:
//       IDLE: start=1 -> latch a, b into shift regs, borrow<=bin, cnt<=0, go RUN.
//       RUN: busy=1. Each cycle, process bit i = current LSB of shift regs:
//            d = a_i ^ b_i ^ br
//            br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
//            Shift a and b right; shift d into the result reg from the MSB side.
//            cnt==N-1 -> go DONE.
//       DONE: done=1 and busy=0 for exactly one cycle.
//            diff <= result reg; bout <= final borrow.
//            start=1 -> accepted as in IDLE (back-to-back), go RUN. Otherwise go IDLE.
//   - Latency: start sampled high at edge 0 -> busy high for cycles 1..N ->
//     done high in cycle N+1.
//     Throughput: one operation per N+1 cycles with back-to-back starts.
//   - Ignored inputs: start while in RUN is ignored; a/b/bin are not sampled then, and
//     changes to them in RUN do not affect the result.
//   - Output hold: diff and bout hold their last value until the next DONE or reset.
//     They do not change during RUN.
//   - Width: cnt is $clog2(N) bits (min 1). N=1 works: RUN lasts exactly one cycle.
//   - Arithmetic: no signed interpretation. Result wraps modulo 2^N.
//     bout is the unsigned borrow.
// TESTING
//   1. N=8: a=200, b=55, bin=0, start pulse -> busy 8 cycles, done in cycle 9;
//      diff=145, bout=0.
//   2. N=8: a=5, b=10, bin=0 -> diff=251, bout=1.
//      Then a=0, b=0, bin=1 -> diff=255, bout=1.
//   3. Start held high through RUN with a/b changing every cycle -> result matches
//      the operands latched at acceptance. Exactly one done per N+1 cycles
//      (back-to-back accepted in DONE).
//   4. Assert rst at RUN cycle 4 of a=100, b=1 -> next cycle busy=0, done=0, diff=0,
//      bout=0; no done pulse follows.
//      A fresh start then completes normally.
//   5. Exhaustive N=4: all a, b in 0..15 and bin in {0,1} -> {bout,diff} equals
//      (a - b - bin) mod 32 for every case.
//   6. N=1: a=0, b=1, bin=0 -> busy 1 cycle, done in cycle 2; diff=1, bout=1.

Source files
------------

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one full-subtractor cell, LSB first.
// Latency: start accepted at edge 0 -> busy cycles 1..N -> done pulse in cycle N+1.
// Backpressure: none; start is ignored while busy, and a back-to-back start is taken in DONE.
//
// Ports:
//   clk_i    clock, all state on rising edge
//   rst_i    synchronous active-high reset (aborts any operation in flight)
//   start_i  request; a_i/b_i/bin_i are sampled when it is accepted (IDLE or DONE)
//   a_i      minuend, N bits
//   b_i      subtrahend, N bits
//   bin_i    borrow-in, subtracted at bit 0
//   busy_o   high while bits are being processed
//   done_o   one-cycle pulse; diff_o/bout_o valid from this cycle on
//   diff_o   (a - b - bin) mod 2^N, held until the next done or reset
//   bout_o   unsigned borrow-out, 1 iff a < b + bin
module serial_borrow_subtractor #(
   parameter int N = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         bin_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] diff_o,
   output logic         bout_o
);

   // Counter needs at least one bit so N=1 still elaborates.
   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  res_q, res_d;
   logic          br_q, br_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [N-1:0]  diff_q, diff_d;
   logic          bout_q, bout_d;

   // Full-subtractor cell on the current LSBs.
   logic          abit, bbit;
   logic          d_bit;
   logic          br_nxt;
   logic [N-1:0]  d_vec;
   logic [N-1:0]  res_shift;

   always_comb begin
      abit   = a_q[0];
      bbit   = b_q[0];
      d_bit  = abit ^ bbit ^ br_q;
      br_nxt = (~abit & bbit) | (~(abit ^ bbit) & br_q);
      // Result fills from the MSB side so that after N shifts bit 0 sits at index 0.
      // Built with a shift/or rather than a slice so N=1 needs no special case.
      d_vec        = '0;
      d_vec[N-1]   = d_bit;
      res_shift    = (res_q >> 1) | d_vec;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         IDLE, DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               br_d    = bin_i;
               res_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_shift;
            br_d  = br_nxt;
            if (cnt_q == LAST) begin
               // Publish on the edge into DONE so outputs are valid with the pulse.
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               diff_d  = res_shift;
               bout_d  = br_nxt;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign diff_o = diff_q;
   assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed bench for serial_borrow_subtractor at N=8, N=4 (exhaustive) and N=1.
// Inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
// Every expected value below is hand-computed or derived from plain integer arithmetic.
module tb_serial_borrow_subtractor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // N=8 instance
   logic       s8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   serial_borrow_subtractor #(.N(8)) u8 (
      .clk_i(clk), .rst_i(rst), .start_i(s8), .a_i(a8), .b_i(b8), .bin_i(bin8),
      .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8)
   );

   // N=4 instance
   logic       s4 = 1'b0, bin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, bout4;
   logic [3:0] diff4;

   serial_borrow_subtractor #(.N(4)) u4 (
      .clk_i(clk), .rst_i(rst), .start_i(s4), .a_i(a4), .b_i(b4), .bin_i(bin4),
      .busy_o(busy4), .done_o(done4), .diff_o(diff4), .bout_o(bout4)
   );

   // N=1 instance
   logic       s1 = 1'b0, bin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, bout1;
   logic [0:0] diff1;

   serial_borrow_subtractor #(.N(1)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(s1), .a_i(a1), .b_i(b1), .bin_i(bin1),
      .busy_o(busy1), .done_o(done1), .diff_o(diff1), .bout_o(bout1)
   );

   // One N=8 operation: counts busy cycles, done pulses and the done cycle index,
   // and checks the held result does not move during RUN.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input logic [7:0] ed, input logic eb);
      int nb, nd, dcyc;
      logic [7:0] prev;
      logic moved;
      @(negedge clk);
      s8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
      @(negedge clk);               // cycle 1
      s8 = 1'b0;
      nb = 0; nd = 0; dcyc = 0; moved = 1'b0; prev = diff8;
      for (int c = 1; c <= 12; c++) begin
         if (busy8) nb++;
         if (done8) begin nd++; dcyc = c; end
         if (nd == 0 && diff8 !== prev) moved = 1'b1;
         if (done8) begin
            check({tag, "_diff"}, 32'(diff8), 32'(ed));
            check({tag, "_bout"}, 32'(bout8), 32'(eb));
         end
         @(negedge clk);
      end
      check({tag, "_busycyc"}, 32'(nb), 32'd8);
      check({tag, "_ndone"}, 32'(nd), 32'd1);
      check({tag, "_donecyc"}, 32'(dcyc), 32'd9);
      check({tag, "_hold"}, 32'(moved), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_diff", 32'(diff8), 32'd0);
      check("rst_bout", 32'(bout8), 32'd0);
      rst = 1'b0;

      // Basic and wraparound cases
      op8("t1", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0);
      op8("t2a", 8'd5, 8'd10, 1'b0, 8'd251, 1'b1);
      op8("t2b", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);
      op8("t2c", 8'd0, 8'd255, 1'b0, 8'd1, 1'b1);
      op8("t2d", 8'd128, 8'd127, 1'b1, 8'd0, 1'b0);

      // start held high, operands scrambled every cycle; op2 accepted in DONE
      // 200-55-0 = 145 b0 ; 17-40-1 = -24 -> 232 b1
      begin
         int nd;
         @(negedge clk);
         s8 = 1'b1; a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0;
         nd = 0;
         for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (done8) nd++;
            if (c == 9) begin
               check("t3_done9", 32'(done8), 32'd1);
               check("t3_diff1", 32'(diff8), 32'd145);
               check("t3_bout1", 32'(bout8), 32'd0);
               a8 = 8'd17; b8 = 8'd40; bin8 = 1'b1;
            end else if (c == 18) begin
               check("t3_done18", 32'(done8), 32'd1);
               check("t3_diff2", 32'(diff8), 32'd232);
               check("t3_bout2", 32'(bout8), 32'd1);
               s8 = 1'b0;
            end else begin
               a8 = 8'(c * 37 + 3); b8 = 8'(c * 91 + 11); bin8 = c[0];
            end
         end
         check("t3_ndone", 32'(nd), 32'd2);
         repeat (3) @(negedge clk);
         check("t3_idle", 32'(busy8), 32'd0);
      end

      // Reset mid-operation aborts it
      begin
         int nd;
         @(negedge clk);
         s8 = 1'b1; a8 = 8'd100; b8 = 8'd1; bin8 = 1'b0;
         @(negedge clk);            // cycle 1
         s8 = 1'b0;
         repeat (3) @(negedge clk); // cycle 4
         check("t4_busy_pre", 32'(busy8), 32'd1);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("t4_busy", 32'(busy8), 32'd0);
         check("t4_done", 32'(done8), 32'd0);
         check("t4_diff", 32'(diff8), 32'd0);
         check("t4_bout", 32'(bout8), 32'd0);
         nd = 0;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
         end
         check("t4_nodone", 32'(nd), 32'd0);
         op8("t4f", 8'd100, 8'd1, 1'b0, 8'd99, 1'b0);
      end

      // Exhaustive N=4: {bout,diff} == (a - b - bin) mod 32, done in cycle 5
      begin
         int errs;
         errs = 0;
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               for (int bi = 0; bi < 2; bi++) begin
                  int e;
                  e = (a - b - bi + 64) % 32;
                  @(negedge clk);
                  s4 = 1'b1; a4 = 4'(a); b4 = 4'(b); bin4 = bi[0];
                  @(negedge clk);
                  s4 = 1'b0;
                  repeat (4) @(negedge clk);
                  if (!done4 || {bout4, diff4} !== 5'(e)) begin
                     errs++;
                     if (errs <= 4)
                        $display("exh4 a=%0d b=%0d bin=%0d got done=%0d %0d want %0d",
                                 a, b, bi, done4, {bout4, diff4}, e);
                  end
               end
         check("exh4_errors", 32'(errs), 32'd0);
      end

      // N=1: 0 - 1 - 0 -> diff 1, bout 1; busy one cycle, done in cycle 2
      @(negedge clk);
      s1 = 1'b1; a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0;
      @(negedge clk);
      s1 = 1'b0;
      check("n1_busy1", 32'(busy1), 32'd1);
      check("n1_done1", 32'(done1), 32'd0);
      @(negedge clk);
      check("n1_busy2", 32'(busy1), 32'd0);
      check("n1_done2", 32'(done1), 32'd1);
      check("n1_diff", 32'(diff1), 32'd1);
      check("n1_bout", 32'(bout1), 32'd1);
      @(negedge clk);
      check("n1_done3", 32'(done1), 32'd0);
      check("n1_hold", 32'(diff1), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
